// File: rtl/segre_if_stage.sv
// Instruction fetch stage: single outstanding fetch, one-entry skid buffer, redirect and bubbles.
// Optional SEGRE_IF_FINISH_HALT_EN stops fetching after the end-of-test instruction is delivered.
module segre_if_stage #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter int unsigned          ADDR_SIZE = 32,
    parameter logic [ADDR_SIZE-1:0] BOOT_ADDR = '0,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = WORD_SIZE'(32'h0000_0013)
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 block_if_i,
    input  logic                 inject_nops_i,
    input  logic                 tkbr_i,
    input  logic [ADDR_SIZE-1:0] new_pc_i,
    output logic                 mem_rd_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    input  logic                 mem_ready_i,
    input  logic [WORD_SIZE-1:0] mem_rdata_i,
    output logic [WORD_SIZE-1:0] instr_o,
    output logic [ADDR_SIZE-1:0] pc_o,
    output logic                 valid_if_o,
    output logic                 halted_o
);

`ifdef SEGRE_IF_FINISH_HALT_EN
    localparam logic [WORD_SIZE-1:0] HaltInstr = WORD_SIZE'(32'hfff0_1073);
    typedef enum logic [1:0] {StReq, StFull, StHalt} state_e;
`else
    typedef enum logic [1:0] {StReq, StFull} state_e;
`endif

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   fetch_pc_q, fetch_pc_d;
    logic [WORD_SIZE-1:0]   instr_q, instr_d;
    logic [ADDR_SIZE-1:0]   pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [WORD_SIZE-1:0]   instr_b_q, instr_b_d;
    logic [ADDR_SIZE-1:0]   pc_b_q, pc_b_d;

    logic                   out_free;
    logic                   load_out;
    logic [WORD_SIZE-1:0]   ld_instr;
    logic [ADDR_SIZE-1:0]   ld_pc;
    logic                   unused_new_pc;

    assign out_free      = !block_if_i && !inject_nops_i;
    assign unused_new_pc = ^new_pc_i[1:0];

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_q    <= StReq;
            fetch_pc_q <= BOOT_ADDR;
            instr_q    <= NOP_INSTR;
            pc_q       <= BOOT_ADDR - ADDR_SIZE'(4);
            valid_q    <= 1'b0;
            instr_b_q  <= NOP_INSTR;
            pc_b_q     <= BOOT_ADDR;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            valid_q    <= valid_d;
            instr_b_q  <= instr_b_d;
            pc_b_q     <= pc_b_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        instr_b_d  = instr_b_q;
        pc_b_d     = pc_b_q;
        load_out   = 1'b0;
        ld_instr   = mem_rdata_i;
        ld_pc      = fetch_pc_q;

        if (tkbr_i) begin
            // Redirect drops any response accepted this cycle and the buffered entry.
            fetch_pc_d = {new_pc_i[ADDR_SIZE-1:2], 2'b00};
            state_d    = StReq;
            instr_d    = NOP_INSTR;
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                StReq: begin
                    if (mem_ready_i) begin
                        fetch_pc_d = fetch_pc_q + ADDR_SIZE'(4);
                        if (out_free) begin
                            load_out = 1'b1;
                        end else begin
                            instr_b_d = mem_rdata_i;
                            pc_b_d    = fetch_pc_q;
                            state_d   = StFull;
                        end
                    end
                end
                StFull: begin
                    if (out_free) begin
                        load_out = 1'b1;
                        ld_instr = instr_b_q;
                        ld_pc    = pc_b_q;
                        state_d  = StReq;
                    end
                end
                default: ;
            endcase

            if (load_out) begin
                instr_d = ld_instr;
                pc_d    = ld_pc;
                valid_d = 1'b1;
`ifdef SEGRE_IF_FINISH_HALT_EN
                if (ld_instr == HaltInstr) begin
                    state_d = StHalt;
                end
`endif
            end else if (inject_nops_i || !block_if_i) begin
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_comb begin
        mem_rd_o   = !rsn_i && (state_q == StReq);
        mem_addr_o = fetch_pc_q;
`ifdef SEGRE_IF_FINISH_HALT_EN
        halted_o   = (state_q == StHalt);
`else
        halted_o   = 1'b0;
`endif
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign valid_if_o = valid_q;

endmodule

// File: tb/tb_segre_if_stage.sv
// Directed bench for segre_if_stage with a parametrised-wait memory model returning rdata=addr.
// Halt checks follow SEGRE_IF_FINISH_HALT_EN when the bench is built with it.
module tb_segre_if_stage;

    logic        clk_i = 1'b0;
    logic        rsn_i = 1'b1;
    logic        block_if_i = 1'b0;
    logic        inject_nops_i = 1'b0;
    logic        tkbr_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        valid_if_o;
    logic        halted_o;

    int tests = 0;
    int failed = 0;
    int wait_cycles = 0;
    int cnt = 0;
    bit halt_mem = 1'b0;

    always #5 clk_i = ~clk_i;

    segre_if_stage dut (
        .clk_i         (clk_i),
        .rsn_i         (rsn_i),
        .block_if_i    (block_if_i),
        .inject_nops_i (inject_nops_i),
        .tkbr_i        (tkbr_i),
        .new_pc_i      (new_pc_i),
        .mem_rd_o      (mem_rd_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ready_i   (mem_ready_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .valid_if_o    (valid_if_o),
        .halted_o      (halted_o)
    );

    // Memory answers after wait_cycles cycles of a held request.
    assign mem_ready_i = mem_rd_o && (cnt == wait_cycles);
    assign mem_rdata_i = (halt_mem && mem_addr_o == 32'h10) ? 32'hfff0_1073 : mem_addr_o;

    always @(posedge clk_i) begin
        if (!mem_rd_o || mem_ready_i || tkbr_i) cnt <= 0;
        else cnt <= cnt + 1;
    end

    task automatic do_reset();
        rsn_i = 1'b1; block_if_i = 1'b0; inject_nops_i = 1'b0; tkbr_i = 1'b0;
        @(posedge clk_i); @(posedge clk_i);
        @(negedge clk_i);
        rsn_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        wait_cycles = 0;
        rsn_i = 1'b1;
        @(posedge clk_i); @(posedge clk_i);
        @(negedge clk_i);
        tests++; if (valid_if_o !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", valid_if_o); end
        tests++; if (instr_o !== 32'h13) begin failed++; $display("FAIL reset_instr got %h exp 00000013", instr_o); end
        tests++; if (pc_o !== 32'hffff_fffc) begin failed++; $display("FAIL reset_pc got %h exp fffffffc", pc_o); end
        tests++; if (mem_rd_o !== 1'b0) begin failed++; $display("FAIL reset_rd got %b exp 0", mem_rd_o); end
        tests++; if (halted_o !== 1'b0) begin failed++; $display("FAIL reset_halted got %b exp 0", halted_o); end
        rsn_i = 1'b0;
        #1;
        tests++; if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            failed++; $display("FAIL reset_first_req got rd=%b addr=%h exp rd=1 addr=0", mem_rd_o, mem_addr_o); end
    endtask

    task automatic test_stream();
        wait_cycles = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            tests++; if (valid_if_o !== 1'b1 || pc_o !== 32'(4 * i) || instr_o !== 32'(4 * i)) begin
                failed++; $display("FAIL stream_out[%0d] got v=%b pc=%h instr=%h exp v=1 pc=%h", i, valid_if_o, pc_o, instr_o, 4 * i); end
            tests++; if (mem_addr_o !== 32'(4 * (i + 1))) begin
                failed++; $display("FAIL stream_addr[%0d] got %h exp %h", i, mem_addr_o, 4 * (i + 1)); end
        end
    endtask

    task automatic test_latency();
        wait_cycles = 2;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tests++; if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h0 || valid_if_o !== 1'b0) begin
                failed++; $display("FAIL lat_wait[%0d] got rd=%b addr=%h v=%b exp rd=1 addr=0 v=0", i, mem_rd_o, mem_addr_o, valid_if_o); end
            @(negedge clk_i);
        end
        tests++; if (valid_if_o !== 1'b1 || pc_o !== 32'h0) begin
            failed++; $display("FAIL lat_first got v=%b pc=%h exp v=1 pc=0", valid_if_o, pc_o); end
        @(negedge clk_i);
        tests++; if (valid_if_o !== 1'b0 || mem_addr_o !== 32'h4) begin
            failed++; $display("FAIL lat_gap got v=%b addr=%h exp v=0 addr=4", valid_if_o, mem_addr_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        tests++; if (valid_if_o !== 1'b1 || pc_o !== 32'h4) begin
            failed++; $display("FAIL lat_second got v=%b pc=%h exp v=1 pc=4", valid_if_o, pc_o); end
    endtask

    task automatic test_block();
        wait_cycles = 0;
        do_reset();
        @(negedge clk_i); @(negedge clk_i);
        block_if_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            tests++; if (mem_rd_o !== 1'b0 || pc_o !== 32'h4 || valid_if_o !== 1'b1) begin
                failed++; $display("FAIL block_hold[%0d] got rd=%b pc=%h v=%b exp rd=0 pc=4 v=1", i, mem_rd_o, pc_o, valid_if_o); end
        end
        block_if_i = 1'b0;
        @(negedge clk_i);
        tests++; if (valid_if_o !== 1'b1 || pc_o !== 32'h8 || instr_o !== 32'h8) begin
            failed++; $display("FAIL block_release got v=%b pc=%h instr=%h exp v=1 pc=8", valid_if_o, pc_o, instr_o); end
        tests++; if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'hc) begin
            failed++; $display("FAIL block_next_req got rd=%b addr=%h exp rd=1 addr=c", mem_rd_o, mem_addr_o); end
    endtask

    task automatic test_branch();
        wait_cycles = 0;
        do_reset();
        @(negedge clk_i); @(negedge clk_i);
        tkbr_i = 1'b1; new_pc_i = 32'h101;
        @(negedge clk_i);
        tkbr_i = 1'b0;
        tests++; if (valid_if_o !== 1'b0 || instr_o !== 32'h13) begin
            failed++; $display("FAIL br_bubble got v=%b instr=%h exp v=0 instr=13", valid_if_o, instr_o); end
        tests++; if (mem_rd_o !== 1'b1 || mem_addr_o !== 32'h100) begin
            failed++; $display("FAIL br_addr got rd=%b addr=%h exp rd=1 addr=100", mem_rd_o, mem_addr_o); end
        @(negedge clk_i);
        tests++; if (valid_if_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== 32'h100) begin
            failed++; $display("FAIL br_target got v=%b pc=%h instr=%h exp v=1 pc=100", valid_if_o, pc_o, instr_o); end
    endtask

    task automatic test_inject();
        wait_cycles = 0;
        do_reset();
        @(negedge clk_i); @(negedge clk_i);
        inject_nops_i = 1'b1;
        @(negedge clk_i);
        inject_nops_i = 1'b0;
        tests++; if (valid_if_o !== 1'b0 || instr_o !== 32'h13 || pc_o !== 32'h4) begin
            failed++; $display("FAIL inj_bubble got v=%b instr=%h pc=%h exp v=0 instr=13 pc=4", valid_if_o, instr_o, pc_o); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            tests++; if (valid_if_o !== 1'b1 || pc_o !== 32'(8 + 4 * i)) begin
                failed++; $display("FAIL inj_resume[%0d] got v=%b pc=%h exp v=1 pc=%h", i, valid_if_o, pc_o, 8 + 4 * i); end
        end
    endtask

    task automatic test_halt();
        wait_cycles = 0;
        halt_mem = 1'b1;
        do_reset();
        for (int i = 0; i < 5; i++) @(negedge clk_i);
        tests++; if (valid_if_o !== 1'b1 || pc_o !== 32'h10 || instr_o !== 32'hfff0_1073) begin
            failed++; $display("FAIL halt_deliver got v=%b pc=%h instr=%h exp v=1 pc=10 instr=fff01073", valid_if_o, pc_o, instr_o); end
`ifdef SEGRE_IF_FINISH_HALT_EN
        for (int i = 0; i < 3; i++) begin
            tests++; if (halted_o !== 1'b1 || mem_rd_o !== 1'b0) begin
                failed++; $display("FAIL halt_stay[%0d] got halted=%b rd=%b exp halted=1 rd=0", i, halted_o, mem_rd_o); end
            @(negedge clk_i);
        end
        tests++; if (valid_if_o !== 1'b0) begin failed++; $display("FAIL halt_idle got v=%b exp 0", valid_if_o); end
        tkbr_i = 1'b1; new_pc_i = 32'h0;
        @(negedge clk_i);
        tkbr_i = 1'b0;
        tests++; if (halted_o !== 1'b0 || mem_rd_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            failed++; $display("FAIL halt_resume got halted=%b rd=%b addr=%h exp halted=0 rd=1 addr=0", halted_o, mem_rd_o, mem_addr_o); end
        @(negedge clk_i);
        tests++; if (valid_if_o !== 1'b1 || pc_o !== 32'h0) begin
            failed++; $display("FAIL halt_refetch got v=%b pc=%h exp v=1 pc=0", valid_if_o, pc_o); end
`else
        tests++; if (halted_o !== 1'b0 || mem_rd_o !== 1'b1 || mem_addr_o !== 32'h14) begin
            failed++; $display("FAIL nohalt_req got halted=%b rd=%b addr=%h exp halted=0 rd=1 addr=14", halted_o, mem_rd_o, mem_addr_o); end
        @(negedge clk_i);
        tests++; if (valid_if_o !== 1'b1 || pc_o !== 32'h14) begin
            failed++; $display("FAIL nohalt_next got v=%b pc=%h exp v=1 pc=14", valid_if_o, pc_o); end
`endif
        halt_mem = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_latency();
        test_block();
        test_branch();
        test_inject();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/segre_if_stage.md
Name: segre_if_stage

Overview:
Instruction fetch stage; sits directly upstream of the decode stage and feeds its instr/pc/valid inputs. It owns the fetch PC and issues one outstanding read at a time to the instruction memory port. It holds a one-entry skid buffer so a response that arrives while decode is blocked is never lost. It handles taken-branch/jump redirects and controller bubbles.

Parameters:
WORD_SIZE, 32, instruction/data width
ADDR_SIZE, 32, PC/address width
BOOT_ADDR, 32'h0000_0000, first fetch address after reset
NOP_INSTR, 32'h0000_0013, encoding driven on instr_o when no valid instruction is present

Ports:
clk_i  in  1  clock, all state updates on rising edge
rsn_i  in  1  reset; synchronous, active-high (1 = reset)
block_if_i  in  1  decode stage blocked; output register must hold
inject_nops_i  in  1  load a bubble into the output register this cycle
tkbr_i  in  1  redirect fetch (taken branch/jump)
new_pc_i  in  ADDR_SIZE  redirect target, sampled when tkbr_i=1
mem_rd_o  out  1  instruction read request
mem_addr_o  out  ADDR_SIZE  request address (word aligned)
mem_ready_i  in  1  response valid for the current request
mem_rdata_i  in  WORD_SIZE  response instruction
instr_o  out  WORD_SIZE  instruction to decode
pc_o  out  ADDR_SIZE  PC of instr_o
valid_if_o  out  1  instr_o/pc_o are a real instruction
halted_o  out  1  fetch halted on end-of-test instruction (feature only; else 0)

Behaviour:
- Reset (rsn_i=1 at edge): state=REQ, fetch_pc=BOOT_ADDR, buffer empty, instr_o=NOP_INSTR, pc_o=BOOT_ADDR-4, valid_if_o=0, halted_o=0. mem_rd_o is forced to 0 while rsn_i=1.
- State: fetch_pc reg; output reg (instr_q, pc_q, valid_q); buffer reg (instr_b, pc_b). FSM states: REQ, FULL, and HALT (feature only).
- REQ:
  - mem_rd_o=1, mem_addr_o=fetch_pc. Request and address stay stable until mem_ready_i.
  - mem_ready_i may assert in the same cycle as the request (zero wait) or any later cycle.
  - Response accepted = REQ && mem_ready_i.
- Output can take data when block_if_i=0 and inject_nops_i=0.
- Accept in REQ with output free: output reg <= {mem_rdata_i, fetch_pc, 1}, fetch_pc += 4, stay in REQ. Throughput is 1 instr/cycle with zero-wait memory; latency is 1 cycle from acceptance to valid_if_o.
- Accept in REQ with output not free: buffer <= {mem_rdata_i, fetch_pc}, fetch_pc += 4, go to FULL.
- FULL:
  - mem_rd_o=0.
  - When output is free: output reg <= {instr_b, pc_b, 1}, go to REQ.
- No accept and output free: valid_q <= 0, instr_q <= NOP_INSTR, pc_q unchanged.
- block_if_i=1 (no inject, no redirect): output reg holds its value.
- inject_nops_i=1 (no redirect): instr_q <= NOP_INSTR, valid_q <= 0, pc_q unchanged. Fetch side treats the output as not free, so no instruction is lost.
- Priority: rsn_i > tkbr_i > inject_nops_i > block_if_i > normal.
- tkbr_i=1:
  - fetch_pc <= new_pc_i; buffer discarded; state <= REQ; output reg <= NOP bubble (valid 0).
  - Any response accepted in the same cycle is dropped.
  - The outstanding request is abandoned. Memory is combinationally addressed, so the new address is presented from the next cycle.
- fetch_pc wraps modulo 2^ADDR_SIZE. Bits [1:0] of new_pc_i are ignored (forced to 0).
- Reset mid-request: the request is dropped and no response is accepted in the reset cycle.

Optional Feature:
SEGRE_IF_FINISH_HALT_EN
- Defined:
  - When the output reg loads 32'hfff01073 with valid=1, the FSM enters HALT: mem_rd_o=0, halted_o=1, no further fetches.
  - The halting instruction itself is delivered normally.
  - HALT is left only by tkbr_i (go to REQ at new_pc_i, halted_o=0) or reset.
- Not defined: the HALT state does not exist, halted_o is tied to 0, and fetch continues past the instruction.

Test Plan:
1. Zero-wait memory returning rdata=addr: release reset -> mem_addr_o 0x0,0x4,0x8...; valid_if_o=1 from the next cycle, with pc_o 0x0,0x4,0x8 on consecutive cycles and instr_o==pc_o.
2. 3-cycle memory latency -> mem_rd_o held high and mem_addr_o=0x0 stable for 3 cycles; one valid instruction every 3 cycles, pc_o 0x0, 0x4.
3. block_if_i=1 for 2 cycles while pc 0x4 is on the output and the 0x8 response arrives -> state FULL, mem_rd_o=0, pc_o held at 0x4; after release pc_o=0x8, then request 0xC.
4. tkbr_i=1, new_pc_i=0x100, in the same cycle as mem_ready_i for 0x8 -> 0x8 never valid; one bubble (valid 0, instr 0x13); next valid pc_o=0x100.
5. inject_nops_i=1 for 1 cycle during streaming -> one cycle of valid 0 and instr 0x13; the following valid pc_o values are contiguous with none skipped.
6. With SEGRE_IF_FINISH_HALT_EN, 0xfff01073 at 0x10 -> delivered at pc_o=0x10, halted_o=1, mem_rd_o=0 indefinitely; tkbr_i to 0x0 -> fetching resumes. Without the macro, 0x14 is fetched.
